// File: rtl/ctrl_pipe_unit_pkg.sv
// Shared encodings and decode helper for the ID/EXE control pipeline.
package ctrl_pipe_unit_pkg;

   // Instruction modes
   localparam logic [1:0] MODE_ARITH  = 2'b00;
   localparam logic [1:0] MODE_MEM    = 2'b01;
   localparam logic [1:0] MODE_BRANCH = 2'b10;

   // Data-processing opcodes
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   // ALU command codes; 0000 means no ALU work (bubble or branch)
   localparam logic [3:0] CMD_NONE = 4'b0000;
   localparam logic [3:0] CMD_MOV  = 4'b0001;
   localparam logic [3:0] CMD_ADD  = 4'b0010;
   localparam logic [3:0] CMD_ADC  = 4'b0011;
   localparam logic [3:0] CMD_SUB  = 4'b0100;
   localparam logic [3:0] CMD_SBC  = 4'b0101;
   localparam logic [3:0] CMD_AND  = 4'b0110;
   localparam logic [3:0] CMD_ORR  = 4'b0111;
   localparam logic [3:0] CMD_EOR  = 4'b1000;
   localparam logic [3:0] CMD_MVN  = 4'b1001;

   // ARM condition field
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Wrong-path flush counter width (FLUSH_CYCLES is 1..15)
   localparam int CNT_W = 4;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   // Decoded control before condition gating
   typedef struct packed {
      logic [3:0] cmd;
      logic       mem_read;
      logic       mem_write;
      logic       wb_en;
      logic       s_upd;
      logic       b_taken;
      logic       illegal;
   } ctrl_t;

   // Translate mode/opcode/S into control; undefined encodings become a
   // bubble with only the illegal flag raised.
   function automatic ctrl_t decode_ctrl(input logic [1:0] mode,
                                         input logic [3:0] op,
                                         input logic       s);
      ctrl_t c;
      c = '0;
      case (mode)
         MODE_ARITH: begin
            c.wb_en = 1'b1;
            c.s_upd = s;
            case (op)
               OP_MOV: c.cmd = CMD_MOV;
               OP_MVN: c.cmd = CMD_MVN;
               OP_ADD: c.cmd = CMD_ADD;
               OP_ADC: c.cmd = CMD_ADC;
               OP_SUB: c.cmd = CMD_SUB;
               OP_SBC: c.cmd = CMD_SBC;
               OP_AND: c.cmd = CMD_AND;
               OP_ORR: c.cmd = CMD_ORR;
               OP_EOR: c.cmd = CMD_EOR;
               OP_CMP: begin
                  c.cmd   = CMD_SUB;
                  c.wb_en = 1'b0;
               end
               OP_TST: begin
                  c.cmd   = CMD_AND;
                  c.wb_en = 1'b0;
               end
               default: begin
                  c         = '0;
                  c.illegal = 1'b1;
               end
            endcase
         end
         MODE_MEM: begin
            // S selects load (read + writeback) versus store
            c.cmd       = CMD_ADD;
            c.mem_read  = s;
            c.wb_en     = s;
            c.mem_write = ~s;
         end
         MODE_BRANCH: begin
            c.b_taken = 1'b1;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ctrl_pipe_unit_cond_check.sv
// ARM condition-field evaluator against an NZCV flag vector (combinational).
module ctrl_pipe_unit_cond_check
   import ctrl_pipe_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic flag_n;
   logic flag_z;
   logic flag_c;
   logic flag_v;

   assign {flag_n, flag_z, flag_c, flag_v} = nzcv;

   // Select the predicate named by the condition field.
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = flag_z;
         COND_NE: pass = ~flag_z;
         COND_CS: pass = flag_c;
         COND_CC: pass = ~flag_c;
         COND_MI: pass = flag_n;
         COND_PL: pass = ~flag_n;
         COND_VS: pass = flag_v;
         COND_VC: pass = ~flag_v;
         COND_HI: pass = flag_c & ~flag_z;
         COND_LS: pass = ~flag_c | flag_z;
         COND_GE: pass = (flag_n == flag_v);
         COND_LT: pass = (flag_n != flag_v);
         COND_GT: pass = ~flag_z & (flag_n == flag_v);
         COND_LE: pass = flag_z | (flag_n != flag_v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Decode controller: decodes the ID instruction, gates it with the condition
// field against NZCV, and registers control into ID/EXE with stall handling
// and a counted wrong-path flush after taken branches.
module ctrl_pipe_unit
   import ctrl_pipe_unit_pkg::*;
#(
   parameter int CMD_W        = 4,
   parameter int RD_W         = 4,
   parameter int FLUSH_CYCLES = 1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            stall_in,
   input  logic [3:0]      cond,
   input  logic [1:0]      mode,
   input  logic [3:0]      op_code,
   input  logic            S,
   input  logic [RD_W-1:0] rd,
   input  logic            flags_we,
   input  logic [3:0]      flags_in,
   output logic            out_valid,
   output logic [CMD_W-1:0] exe_cmd,
   output logic            mem_read,
   output logic            mem_write,
   output logic            wb_en,
   output logic            s_upd,
   output logic            b_taken,
   output logic [RD_W-1:0] rd_out,
   output logic [3:0]      status_out,
   output logic            flush_if,
   output logic            illegal
);

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        sr_q, sr_d;
   logic              out_valid_q, out_valid_d;
   logic [CMD_W-1:0]  exe_cmd_q, exe_cmd_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              wb_en_q, wb_en_d;
   logic              s_upd_q, s_upd_d;
   logic              b_taken_q, b_taken_d;
   logic [RD_W-1:0]   rd_out_q, rd_out_d;
   logic              illegal_q, illegal_d;

   logic [3:0]        eff_flags;
   logic              cond_pass;
   ctrl_t             dec;
   logic              accept;
   logic              branch_go;

   // A flag write from EXE in this cycle is visible to the condition check.
   assign eff_flags = flags_we ? flags_in : sr_q;

   ctrl_pipe_unit_cond_check u_cond_check (
      .cond (cond),
      .nzcv (eff_flags),
      .pass (cond_pass)
   );

   assign dec       = decode_ctrl(mode, op_code, S);
   assign accept    = in_valid & ~stall_in & (state_q == ST_RUN);
   assign branch_go = accept & dec.b_taken & cond_pass;

   assign in_ready   = ~stall_in;
   assign flush_if   = branch_go;
   assign out_valid  = out_valid_q;
   assign exe_cmd    = exe_cmd_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign wb_en      = wb_en_q;
   assign s_upd      = s_upd_q;
   assign b_taken    = b_taken_q;
   assign rd_out     = rd_out_q;
   assign status_out = sr_q;
   assign illegal    = illegal_q;

   // Next-state for status, ID/EXE register and flush FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = flags_we ? flags_in : sr_q;
      out_valid_d = out_valid_q;
      exe_cmd_d   = exe_cmd_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      wb_en_d     = wb_en_q;
      s_upd_d     = s_upd_q;
      b_taken_d   = b_taken_q;
      rd_out_d    = rd_out_q;
      illegal_d   = illegal_q;

      // A stall freezes ID/EXE and the FSM; only the status register moves.
      if (!stall_in) begin
         out_valid_d = 1'b0;
         exe_cmd_d   = '0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         wb_en_d     = 1'b0;
         s_upd_d     = 1'b0;
         b_taken_d   = 1'b0;
         rd_out_d    = '0;

         if (accept) begin
            out_valid_d = 1'b1;
            exe_cmd_d   = CMD_W'(dec.cmd);
            rd_out_d    = rd;
            illegal_d   = dec.illegal;
            // Failed condition keeps the slot valid but disables all effects
            if (cond_pass) begin
               mem_read_d  = dec.mem_read;
               mem_write_d = dec.mem_write;
               wb_en_d     = dec.wb_en;
               s_upd_d     = dec.s_upd;
               b_taken_d   = dec.b_taken;
            end
         end

         case (state_q)
            ST_RUN: begin
               if (branch_go) begin
                  state_d = ST_FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end
            end
            ST_FLUSH: begin
               // Input is discarded this cycle; leave when the count expires
               cnt_d = cnt_q - 1'b1;
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Register all state; reset abandons any flush in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         sr_q        <= '0;
         out_valid_q <= 1'b0;
         exe_cmd_q   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         wb_en_q     <= 1'b0;
         s_upd_q     <= 1'b0;
         b_taken_q   <= 1'b0;
         rd_out_q    <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         out_valid_q <= out_valid_d;
         exe_cmd_q   <= exe_cmd_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         wb_en_q     <= wb_en_d;
         s_upd_q     <= s_upd_d;
         b_taken_q   <= b_taken_d;
         rd_out_q    <= rd_out_d;
         illegal_q   <= illegal_d;
      end
   end

endmodule
